// File: rtl/pdp8lpbctl_pkg.sv
// Shared constants, register map and sequencer state for the PDP-8/L pulse bit generator controller.
package pdp8lpbctl_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned LEVEL_W = 7;

  localparam logic [1:0] REG_IDENT = 2'd0;
  localparam logic [1:0] REG_CFG   = 2'd1;
  localparam logic [1:0] REG_STAT  = 2'd2;
  localparam logic [1:0] REG_FIFO  = 2'd3;

  localparam logic [1:0] GEN_REG_CFG  = 2'd1;
  localparam logic [1:0] GEN_REG_RATE = 2'd2;

  localparam logic [DATA_W-1:0] IDENT_VALUE = 32'h5043_1004;
  localparam logic [DATA_W-1:0] CFG_RESET   = 32'h004A_E000;

  localparam int unsigned ST_ENABLE    = 31;
  localparam int unsigned ST_OVERFLOW  = 30;
  localparam int unsigned ST_EMPTY     = 29;
  localparam int unsigned ST_FULL      = 28;
  localparam int unsigned ST_LEVEL_LSB = 16;
  localparam int unsigned ST_PACK_LSB  = 8;

  localparam int unsigned CTL_ENABLE = 31;
  localparam int unsigned CTL_CLEAR  = 30;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FWD    = 2'd1,
    ST_SETTLE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/pdp8lpbfifo.sv
// Synchronous DEPTH x 32 word FIFO; push and pop together are accepted when full.
module pdp8lpbfifo #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = AW + 1
) (
  input  logic          CLOCK,
  input  logic          RESET_N,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [31:0]   wdata,
  output logic [31:0]   head,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  always_ff @(posedge CLOCK) begin
    if (do_push && !clear) mem[wptr] <= wdata;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/pdp8lpbctl.sv
// PDP-8/L pulse bit generator controller: config forwarding sequencer plus sample packer and FIFO.
// Optional build macro PDP8LPBCTL_DROPCNT_EN adds a saturating dropped-word counter in status [15:0].
module pdp8lpbctl
  import pdp8lpbctl_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        CSTEP,
  input  logic        armwrite,
  input  logic        armread,
  input  logic [1:0]  armraddr,
  input  logic [1:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic        sampstrobe,
  input  logic [7:0]  sampbyte,
  output logic        genwrite,
  output logic [1:0]  genwaddr,
  output logic [31:0] genwdata
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  seq_state_t  state;
  logic [31:0] shadow_cfg;
  logic [31:0] shadow_rate;
  logic        pend_cfg;
  logic        pend_rate;
  logic        enable;
  logic        overflow;
  logic [23:0] pack_sr;
  logic [1:0]  pack_cnt;

  logic          wr_cfg, wr_ctl, wr_rate, clr;
  logic          go_fwd, fwd_cfg, capture;
  logic          push_req, pop_req, drop;
  logic [31:0]   push_word;
  logic [31:0]   fifo_head;
  logic [LW-1:0] fifo_level;
  logic          fifo_full, fifo_empty;
  logic [31:0]   status;

  assign wr_cfg    = armwrite && (armwaddr == REG_CFG);
  assign wr_ctl    = armwrite && (armwaddr == REG_STAT);
  assign wr_rate   = armwrite && (armwaddr == REG_FIFO);
  assign clr       = wr_ctl && armwdata[CTL_CLEAR];
  assign go_fwd    = (state == ST_IDLE) && (pend_cfg || wr_cfg || pend_rate || wr_rate);
  assign fwd_cfg   = pend_cfg || wr_cfg;
  // Any packer clear in the same cycle outranks the capture.
  assign capture   = enable && (state == ST_IDLE) && CSTEP && sampstrobe
                     && !go_fwd && !clr && !wr_rate;
  assign push_word = {pack_sr, sampbyte};
  assign push_req  = capture && (pack_cnt == 2'd3);
  assign pop_req   = armread && (armraddr == REG_FIFO) && !fifo_empty;
  assign drop      = push_req && fifo_full && !pop_req;

  pdp8lpbfifo #(.DEPTH(DEPTH)) u_fifo (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .clear   (clr),
    .push    (push_req),
    .pop     (pop_req),
    .wdata   (push_word),
    .head    (fifo_head),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Forwarding sequencer; a config write in IDLE is forwarded on the very next cycle.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= ST_IDLE;
      genwrite    <= 1'b0;
      genwaddr    <= 2'd0;
      genwdata    <= 32'd0;
      shadow_cfg  <= CFG_RESET;
      shadow_rate <= 32'd0;
      pend_cfg    <= 1'b0;
      pend_rate   <= 1'b0;
    end else begin
      genwrite <= 1'b0;
      if (wr_cfg)  shadow_cfg  <= armwdata;
      if (wr_rate) shadow_rate <= armwdata;
      pend_cfg  <= (pend_cfg || wr_cfg) && !(go_fwd && fwd_cfg);
      pend_rate <= (pend_rate || wr_rate) && !(go_fwd && !fwd_cfg);
      case (state)
        ST_IDLE: begin
          if (go_fwd) begin
            state    <= ST_FWD;
            genwrite <= 1'b1;
            if (fwd_cfg) begin
              genwaddr <= GEN_REG_CFG;
              genwdata <= wr_cfg ? armwdata : shadow_cfg;
            end else begin
              genwaddr <= GEN_REG_RATE;
              genwdata <= wr_rate ? armwdata : shadow_rate;
            end
          end
        end
        ST_FWD:    state <= ST_SETTLE;
        ST_SETTLE: if (CSTEP) state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Capture control, packer and sticky overflow.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      enable   <= 1'b0;
      overflow <= 1'b0;
      pack_sr  <= 24'd0;
      pack_cnt <= 2'd0;
    end else begin
      if (wr_ctl) enable <= armwdata[CTL_ENABLE];
      if (clr)       overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
      if (clr || wr_rate || go_fwd) begin
        pack_sr  <= 24'd0;
        pack_cnt <= 2'd0;
      end else if (capture) begin
        pack_sr  <= push_word[23:0];
        pack_cnt <= pack_cnt + 2'd1;
      end
    end
  end

`ifdef PDP8LPBCTL_DROPCNT_EN
  logic [15:0] dropcnt;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N)                         dropcnt <= 16'd0;
    else if (clr)                         dropcnt <= 16'd0;
    else if (drop && dropcnt != 16'hFFFF) dropcnt <= dropcnt + 16'd1;
  end
`endif

  // Status layout; the drop counter takes over the low half when present.
  always_comb begin
    status                             = 32'd0;
    status[ST_ENABLE]                  = enable;
    status[ST_OVERFLOW]                = overflow;
    status[ST_EMPTY]                   = fifo_empty;
    status[ST_FULL]                    = fifo_full;
    status[ST_LEVEL_LSB +: LEVEL_W]    = LEVEL_W'(fifo_level);
`ifdef PDP8LPBCTL_DROPCNT_EN
    status[15:0]                       = dropcnt;
`else
    status[ST_PACK_LSB +: 2]           = pack_cnt;
`endif
  end

  always_comb begin
    armrdata = 32'd0;
    case (armraddr)
      REG_IDENT: armrdata = IDENT_VALUE;
      REG_CFG:   armrdata = shadow_cfg;
      REG_STAT:  armrdata = status;
      REG_FIFO:  armrdata = fifo_empty ? 32'd0 : fifo_head;
      default:   armrdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_pdp8lpbctl.sv
// Directed self-checking bench for pdp8lpbctl (DEPTH=16); honours PDP8LPBCTL_DROPCNT_EN.
module tb_pdp8lpbctl;

  logic        CLOCK = 1'b0;
  logic        RESET_N;
  logic        CSTEP;
  logic        armwrite;
  logic        armread;
  logic [1:0]  armraddr;
  logic [1:0]  armwaddr;
  logic [31:0] armwdata;
  logic [31:0] armrdata;
  logic        sampstrobe;
  logic [7:0]  sampbyte;
  logic        genwrite;
  logic [1:0]  genwaddr;
  logic [31:0] genwdata;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  pdp8lpbctl #(.DEPTH(16)) dut (
    .CLOCK      (CLOCK),
    .RESET_N    (RESET_N),
    .CSTEP      (CSTEP),
    .armwrite   (armwrite),
    .armread    (armread),
    .armraddr   (armraddr),
    .armwaddr   (armwaddr),
    .armwdata   (armwdata),
    .armrdata   (armrdata),
    .sampstrobe (sampstrobe),
    .sampbyte   (sampbyte),
    .genwrite   (genwrite),
    .genwaddr   (genwaddr),
    .genwdata   (genwdata)
  );

  always #5 CLOCK = ~CLOCK;

`ifdef PDP8LPBCTL_DROPCNT_EN
  localparam logic [31:0] DROP1 = 32'h0000_0001;
  localparam logic [31:0] PACK2 = 32'h0000_0000;
`else
  localparam logic [31:0] DROP1 = 32'h0000_0000;
  localparam logic [31:0] PACK2 = 32'h0000_0200;
`endif

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic arm_write(input logic [1:0] a, input logic [31:0] d);
    armwrite = 1'b1;
    armwaddr = a;
    armwdata = d;
    tick();
    armwrite = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    armraddr = a;
    #1;
    d = armrdata;
  endtask

  task automatic send_byte(input logic [7:0] b);
    sampstrobe = 1'b1;
    sampbyte   = b;
    tick();
    sampstrobe = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    RESET_N = 1'b0;
    repeat (3) @(posedge CLOCK);
    #1;
    n_tests++;
    if ({genwrite, genwaddr, genwdata} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_gen: got %b/%h/%h want 0/0/0", genwrite, genwaddr, genwdata);
    end
    RESET_N = 1'b1;
    tick();
    rd(2'd0, d);
    n_tests++;
    if (d !== 32'h5043_1004) begin n_fail++; $display("FAIL reset_ident: got %h want 50431004", d); end
    rd(2'd1, d);
    n_tests++;
    if (d !== 32'h004A_E000) begin n_fail++; $display("FAIL reset_shadow: got %h want 004ae000", d); end
    rd(2'd2, d);
    n_tests++;
    if (d !== 32'h2000_0000) begin n_fail++; $display("FAIL reset_status: got %h want 20000000", d); end
    rd(2'd3, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_head: got %h want 0", d); end
  endtask

  task automatic test_forward();
    logic [31:0] d;
    arm_write(2'd1, 32'h8000_0000);
    n_tests++;
    if ({genwrite, genwaddr, genwdata} !== {1'b1, 2'd1, 32'h8000_0000}) begin
      n_fail++;
      $display("FAIL fwd_n1: got %b/%h/%h want 1/1/80000000", genwrite, genwaddr, genwdata);
    end
    tick();
    n_tests++;
    if (genwrite !== 1'b0) begin n_fail++; $display("FAIL fwd_n2: genwrite got %b want 0", genwrite); end
    tick();
    // Back in IDLE at N+3: a write now must forward at N+4.
    arm_write(2'd1, 32'h0000_0001);
    n_tests++;
    if ({genwrite, genwdata} !== {1'b1, 32'h0000_0001}) begin
      n_fail++;
      $display("FAIL fwd_idle_n3: got %b/%h want 1/00000001", genwrite, genwdata);
    end
    rd(2'd1, d);
    n_tests++;
    if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL fwd_shadow: got %h want 00000001", d); end
    repeat (3) tick();

    // SETTLE held by CSTEP=0; a pending write waits for one CSTEP cycle.
    CSTEP = 1'b0;
    arm_write(2'd1, 32'hCAFE_0001);
    n_tests++;
    if ({genwrite, genwdata} !== {1'b1, 32'hCAFE_0001}) begin
      n_fail++;
      $display("FAIL settle_fwd1: got %b/%h want 1/cafe0001", genwrite, genwdata);
    end
    tick();
    arm_write(2'd1, 32'hCAFE_0002);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (genwrite !== 1'b0) begin n_fail++; $display("FAIL settle_hold%0d: genwrite got %b want 0", i, genwrite); end
      if (i == 1) CSTEP = 1'b1;
      tick();
    end
    n_tests++;
    if ({genwrite, genwaddr, genwdata} !== {1'b1, 2'd1, 32'hCAFE_0002}) begin
      n_fail++;
      $display("FAIL settle_fwd2: got %b/%h/%h want 1/1/cafe0002", genwrite, genwaddr, genwdata);
    end
    repeat (3) tick();
  endtask

  task automatic test_capture();
    logic [31:0] d;
    arm_write(2'd2, 32'h8000_0000);
    send_byte(8'h11);
    send_byte(8'h22);
    rd(2'd2, d);
    n_tests++;
    if (d !== (32'hA000_0000 | PACK2)) begin
      n_fail++;
      $display("FAIL cap_partial: got %h want %h", d, 32'hA000_0000 | PACK2);
    end
    send_byte(8'h33);
    send_byte(8'h44);
    rd(2'd2, d);
    n_tests++;
    if (d !== 32'h8001_0000) begin n_fail++; $display("FAIL cap_level1: got %h want 80010000", d); end
    rd(2'd3, d);
    n_tests++;
    if (d !== 32'h1122_3344) begin n_fail++; $display("FAIL cap_word: got %h want 11223344", d); end
    armread = 1'b1;
    tick();
    armread = 1'b0;
    rd(2'd2, d);
    n_tests++;
    if (d !== 32'hA000_0000) begin n_fail++; $display("FAIL cap_empty: got %h want a0000000", d); end
    rd(2'd3, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL cap_head0: got %h want 0", d); end
    armread = 1'b1;
    tick();
    armread = 1'b0;
    rd(2'd2, d);
    n_tests++;
    if (d !== 32'hA000_0000) begin n_fail++; $display("FAIL cap_empty_pop: got %h want a0000000", d); end
  endtask

  task automatic fill16();
    for (int w = 0; w < 16; w++)
      for (int k = 0; k < 4; k++) send_byte(8'(w * 4 + k));
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    fill16();
    rd(2'd2, d);
    n_tests++;
    if (d !== 32'h9010_0000) begin n_fail++; $display("FAIL ovf_full: got %h want 90100000", d); end
    for (int k = 0; k < 4; k++) send_byte(8'hE0 + 8'(k));
    rd(2'd2, d);
    n_tests++;
    if (d !== (32'hD010_0000 | DROP1)) begin
      n_fail++;
      $display("FAIL ovf_set: got %h want %h", d, 32'hD010_0000 | DROP1);
    end
    rd(2'd3, d);
    n_tests++;
    if (d !== 32'h0001_0203) begin n_fail++; $display("FAIL ovf_head: got %h want 00010203", d); end
    arm_write(2'd2, 32'hC000_0000);
    rd(2'd2, d);
    n_tests++;
    if (d !== 32'hA000_0000) begin n_fail++; $display("FAIL ovf_clear: got %h want a0000000", d); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] d;
    logic [31:0] exp;
    fill16();
    send_byte(8'hA0);
    send_byte(8'hA1);
    send_byte(8'hA2);
    sampstrobe = 1'b1;
    sampbyte   = 8'hA3;
    armread    = 1'b1;
    rd(2'd3, d);
    n_tests++;
    if (d !== 32'h0001_0203) begin n_fail++; $display("FAIL fp_head: got %h want 00010203", d); end
    tick();
    sampstrobe = 1'b0;
    armread    = 1'b0;
    rd(2'd2, d);
    n_tests++;
    if (d !== 32'h9010_0000) begin n_fail++; $display("FAIL fp_status: got %h want 90100000", d); end
    for (int w = 1; w <= 16; w++) begin
      exp = (w == 16) ? 32'hA0A1_A2A3
                      : {8'(w * 4), 8'(w * 4 + 1), 8'(w * 4 + 2), 8'(w * 4 + 3)};
      rd(2'd3, d);
      n_tests++;
      if (d !== exp) begin n_fail++; $display("FAIL fp_drain%0d: got %h want %h", w, d, exp); end
      armread = 1'b1;
      tick();
      armread = 1'b0;
    end
    rd(2'd2, d);
    n_tests++;
    if (d !== 32'hA000_0000) begin n_fail++; $display("FAIL fp_drained: got %h want a0000000", d); end
  endtask

  task automatic test_rate_during_settle();
    logic [31:0] d;
    CSTEP = 1'b0;
    arm_write(2'd1, 32'h1234_5678);
    n_tests++;
    if ({genwrite, genwaddr} !== {1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL rs_fwd1: got %b/%h want 1/1", genwrite, genwaddr);
    end
    send_byte(8'h55);
    sampstrobe = 1'b1;
    sampbyte   = 8'h66;
    arm_write(2'd3, 32'h0000_0055);
    send_byte(8'h77);
    CSTEP = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (genwrite !== 1'b0) begin n_fail++; $display("FAIL rs_wait%0d: genwrite got %b want 0", i, genwrite); end
      tick();
    end
    n_tests++;
    if ({genwrite, genwaddr, genwdata} !== {1'b1, 2'd2, 32'h0000_0055}) begin
      n_fail++;
      $display("FAIL rs_fwd2: got %b/%h/%h want 1/2/00000055", genwrite, genwaddr, genwdata);
    end
    repeat (3) tick();
    rd(2'd2, d);
    n_tests++;
    if (d !== 32'hA000_0000) begin n_fail++; $display("FAIL rs_nocap: got %h want a0000000", d); end
  endtask

  task automatic test_reset_mid_forward();
    logic [31:0] d;
    logic        seen;
    arm_write(2'd1, 32'h0BAD_0BAD);
    n_tests++;
    if (genwrite !== 1'b1) begin n_fail++; $display("FAIL rst_fwd: genwrite got %b want 1", genwrite); end
    RESET_N = 1'b0;
    #1;
    n_tests++;
    if ({genwrite, genwaddr} !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_async: got %b/%h want 0/0", genwrite, genwaddr);
    end
    tick();
    RESET_N = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (genwrite) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_nogen: genwrite seen %b want 0", seen); end
    rd(2'd1, d);
    n_tests++;
    if (d !== 32'h004A_E000) begin n_fail++; $display("FAIL rst_shadow: got %h want 004ae000", d); end
    rd(2'd2, d);
    n_tests++;
    if (d !== 32'h2000_0000) begin n_fail++; $display("FAIL rst_status: got %h want 20000000", d); end
  endtask

  initial begin
    RESET_N    = 1'b0;
    CSTEP      = 1'b1;
    armwrite   = 1'b0;
    armread    = 1'b0;
    armraddr   = 2'd0;
    armwaddr   = 2'd0;
    armwdata   = 32'd0;
    sampstrobe = 1'b0;
    sampbyte   = 8'd0;
    test_reset();
    test_forward();
    test_capture();
    test_overflow();
    test_full_push_pop();
    test_rate_during_settle();
    test_reset_mid_forward();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
